usb_attach_ctrl: RTL and testbench
==================================

Name: usb_attach_ctrl

Overview:
- Parametrised reset-and-attach sequencer between the clock/PLL section and the usb_cdc core of a board top level.
- Synchronises an asynchronous active-high reset and produces the active-low reset for the USB core and application.
- Times the D+ 1.5 kOhm pull-up attach and supports soft detach/re-enumeration, which forces a detach window and a fresh attach.
- Drives a status LED that shows attach progress and blinks off on USB activity.

Parameters:
- TICK_DIV, 16: clk_i cycles per timing tick, >=1; 1 means every cycle is a tick.
- SYNC_STAGES, 2: reset synchroniser depth, >=2.
- ATTACH_TICKS, 16384: ticks in WAIT before the pull-up asserts, >=1.
- DETACH_TICKS, 16384: ticks the pull-up is held off after a detach request, >=1.
- BLINK_TICKS, 65536: ticks the LED is forced off after an activity pulse, >=1.

Ports:
- clk_i  in  1  single block clock.
- rst_i  in  1  asynchronous active-high reset, e.g. the inverted PLL lock.
- detach_i  in  1  single-cycle soft-detach request.
- activity_i  in  1  single-cycle USB traffic pulse.
- rstn_o  out  1  synchronised active-low reset for the USB core and application.
- usb_pu_o  out  1  pull-up enable.
- led_o  out  1  status LED, 1 = on.
- state_o  out  2  state encoding: 0 RESET, 1 WAIT, 2 ATTACHED, 3 DETACH.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is asynchronous, active-high.
- Reset assertion: rst_i=1 immediately clears the synchroniser, state, tick prescaler, tick counters and all registered outputs (rstn_o=0, usb_pu_o=0, led_o=0, state_o=0), with no clock required.
- Reset release: the synchroniser shifts 1s in on clk_i. The internal sync reset releases on the SYNC_STAGES-th rising edge after rst_i falls.
- State machine, RESET: stays in RESET while the sync reset is active. On the first edge after release, moves to WAIT and rstn_o=1 registered on the same edge.
- Tick prescaler: counts 0..TICK_DIV-1 and emits a 1-cycle tick on terminal count. It is cleared on every state change, so tick phase is deterministic.
- Tick counter: width is clog2 of max(ATTACH_TICKS, DETACH_TICKS, BLINK_TICKS)+1. It is cleared on every state change and increments on tick.
- WAIT:
  - usb_pu_o=0, led_o=1, rstn_o=1.
  - On the tick that brings the count to ATTACH_TICKS, move to ATTACHED. usb_pu_o rises exactly ATTACH_TICKS*TICK_DIV cycles after state_o became 1.
  - detach_i in WAIT restarts the attach count: prescaler and counter are cleared and the state stays WAIT.
  - If detach_i coincides with the completing tick, detach wins and no attach occurs.
- ATTACHED:
  - usb_pu_o=1, rstn_o=1.
  - led_o=1 unless a blink is active.
  - activity_i loads the blink counter with BLINK_TICKS; led_o=0 from the next edge until the blink counter reaches 0. The blink counter decrements on ticks.
  - A new activity_i during a blink reloads the counter (retrigger).
  - The blink counter is independent of the state prescaler and has its own tick source: a free-running prescaler, cleared only by reset.
  - detach_i moves to DETACH on the next edge.
- DETACH:
  - usb_pu_o=0, rstn_o=0 (USB core held in reset for clean re-enumeration), led_o=0.
  - detach_i and activity_i are ignored.
  - After DETACH_TICKS ticks, moves to WAIT, with rstn_o=1 on the same edge.
- activity_i outside ATTACHED is ignored, and the blink counter is cleared on leaving ATTACHED.
- Reset mid-operation: any state returns to RESET asynchronously, and usb_pu_o drops immediately. After release the full sequence repeats.
- All outputs are registered with no combinational path from inputs.
- Widths: all counters are unsigned and saturate or clear and never wrap. The compare is an equality test against the parameter value.

Test Plan (TICK_DIV=4, SYNC_STAGES=2, ATTACH_TICKS=8, DETACH_TICKS=5, BLINK_TICKS=3):
- Power-up: rst_i=1 for 10 cycles, then released -> rstn_o=0 and state_o=0 through edge 2; state_o=1 and rstn_o=1 at edge 3; led_o=1; usb_pu_o=1 and state_o=2 exactly 32 cycles after state_o=1.
- Activity blink: in ATTACHED, pulse activity_i once -> led_o=0 for 12±3 cycles, then 1. A second pulse 4 cycles after the first extends the off time to 12±3 cycles from the second pulse.
- Soft detach: in ATTACHED, pulse detach_i -> next edge usb_pu_o=0, rstn_o=0, state_o=3. After 20 cycles, state_o=1 and rstn_o=1. After a further 32 cycles, usb_pu_o=1.
- Detach during WAIT: pulse detach_i at WAIT cycle 31, coinciding with the final tick -> no attach; usb_pu_o stays 0; attach occurs 32 cycles after the pulse.
- Async reset mid-ATTACHED: assert rst_i between clock edges -> usb_pu_o, rstn_o and led_o are 0 before the next edge and state_o=0. After release, the power-up timing repeats exactly.
- Ignored inputs: activity_i in WAIT/DETACH and detach_i in DETACH/RESET -> no change in state_o or outputs; DETACH duration stays 20 cycles.

Source files
------------

// File: rtl/usb_attach_ctrl.sv
// Reset synchroniser and D+ pull-up attach sequencer for the usb_cdc core.
// Times attach/detach windows in prescaled ticks and drives a status LED.
module usb_attach_ctrl #(
  parameter int unsigned TICK_DIV     = 16,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned ATTACH_TICKS = 16384,
  parameter int unsigned DETACH_TICKS = 16384,
  parameter int unsigned BLINK_TICKS  = 65536
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       detach_i,
  input  logic       activity_i,
  output logic       rstn_o,
  output logic       usb_pu_o,
  output logic       led_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_WAIT     = 2'd1,
    ST_ATTACHED = 2'd2,
    ST_DETACH   = 2'd3
  } state_e;

  localparam int unsigned MAX_AD    = (ATTACH_TICKS > DETACH_TICKS) ? ATTACH_TICKS : DETACH_TICKS;
  localparam int unsigned MAX_TICKS = (MAX_AD > BLINK_TICKS) ? MAX_AD : BLINK_TICKS;
  localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
  localparam int unsigned PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] ATTACH_LAST = CNT_W'(ATTACH_TICKS - 1);
  localparam logic [CNT_W-1:0] DETACH_LAST = CNT_W'(DETACH_TICKS - 1);
  localparam logic [CNT_W-1:0] BLINK_LOAD  = CNT_W'(BLINK_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_TICKS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_rst_s;

  state_e                 state_q, state_d;
  logic [PRE_W-1:0]       presc_q, presc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PRE_W-1:0]       bpresc_q, bpresc_d;
  logic [CNT_W-1:0]       blink_q, blink_d;
  logic                   rstn_q, rstn_d;
  logic                   pu_q, pu_d;
  logic                   led_q, led_d;

  logic                   tick_s;
  logic                   btick_s;
  logic                   restart_s;
  logic                   change_s;

  // Reset synchroniser: release is delayed SYNC_STAGES edges after rst_i falls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_s = ~sync_q[SYNC_STAGES-1];
  assign tick_s     = (presc_q == PRE_LAST);
  assign btick_s    = (bpresc_q == PRE_LAST);

  // Next-state selection; a detach in WAIT outranks the completing tick.
  always_comb begin
    state_d   = state_q;
    restart_s = 1'b0;
    case (state_q)
      ST_RESET: begin
        state_d = sync_rst_s ? ST_RESET : ST_WAIT;
      end
      ST_WAIT: begin
        if (detach_i) begin
          restart_s = 1'b1;
        end else if (tick_s && (cnt_q == ATTACH_LAST)) begin
          state_d = ST_ATTACHED;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ATTACHED: begin
        state_d = detach_i ? ST_DETACH : ST_ATTACHED;
      end
      ST_DETACH: begin
        state_d = (tick_s && (cnt_q == DETACH_LAST)) ? ST_WAIT : ST_DETACH;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  assign change_s = restart_s || (state_d != state_q);

  // Tick prescaler and tick counter restart on any state change or WAIT restart.
  always_comb begin
    if (change_s || tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
    if (change_s) begin
      cnt_d = '0;
    end else if (tick_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Blink timer runs off its own free-running prescaler; a new pulse reloads it.
  always_comb begin
    bpresc_d = btick_s ? '0 : bpresc_q + 1'b1;
    if ((state_q == ST_ATTACHED) && (state_d == ST_ATTACHED)) begin
      if (activity_i) begin
        blink_d = BLINK_LOAD;
      end else if (btick_s && (blink_q != '0)) begin
        blink_d = blink_q - 1'b1;
      end else begin
        blink_d = blink_q;
      end
    end else begin
      blink_d = '0;
    end
  end

  // Output decode from the next state so outputs change on the transition edge.
  always_comb begin
    case (state_d)
      ST_RESET: begin
        rstn_d = 1'b0;
        pu_d   = 1'b0;
        led_d  = 1'b0;
      end
      ST_WAIT: begin
        rstn_d = 1'b1;
        pu_d   = 1'b0;
        led_d  = 1'b1;
      end
      ST_ATTACHED: begin
        rstn_d = 1'b1;
        pu_d   = 1'b1;
        led_d  = (blink_d == '0);
      end
      ST_DETACH: begin
        rstn_d = 1'b0;
        pu_d   = 1'b0;
        led_d  = 1'b0;
      end
      default: begin
        rstn_d = 1'b0;
        pu_d   = 1'b0;
        led_d  = 1'b0;
      end
    endcase
  end

  // State, timers and registered outputs; rst_i clears everything without a clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_RESET;
      presc_q  <= '0;
      cnt_q    <= '0;
      bpresc_q <= '0;
      blink_q  <= '0;
      rstn_q   <= 1'b0;
      pu_q     <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      bpresc_q <= bpresc_d;
      blink_q  <= blink_d;
      rstn_q   <= rstn_d;
      pu_q     <= pu_d;
      led_q    <= led_d;
    end
  end

  assign rstn_o   = rstn_q;
  assign usb_pu_o = pu_q;
  assign led_o    = led_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_usb_attach_ctrl.sv
// Bench for usb_attach_ctrl: event-time reference model compared every cycle,
// directed timing pins, then randomized detach/activity/reset traffic.
module tb_usb_attach_ctrl;

  localparam int TD = 4;
  localparam int SS = 2;
  localparam int AT = 8;
  localparam int DT = 5;
  localparam int BT = 3;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       detach_i;
  logic       activity_i;
  logic       rstn_o;
  logic       usb_pu_o;
  logic       led_o;
  logic [1:0] state_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: edges since reset release, state, state entry edge, blink end edge.
  int edges;
  int m_state;
  int m_entry;
  int m_blink_end;

  usb_attach_ctrl #(
    .TICK_DIV    (TD),
    .SYNC_STAGES (SS),
    .ATTACH_TICKS(AT),
    .DETACH_TICKS(DT),
    .BLINK_TICKS (BT)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .detach_i  (detach_i),
    .activity_i(activity_i),
    .rstn_o    (rstn_o),
    .usb_pu_o  (usb_pu_o),
    .led_o     (led_o),
    .state_o   (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic model_reset();
    m_state     = 0;
    edges       = 0;
    m_entry     = 0;
    m_blink_end = 0;
  endtask

  // One rising edge: times are plain edge arithmetic, ticks fall on multiples of TD.
  task automatic model_edge();
    edges++;
    case (m_state)
      0: if (edges > SS) begin m_state = 1; m_entry = edges; end
      1: begin
        if (detach_i) m_entry = edges;
        else if (edges - m_entry == AT * TD) begin m_state = 2; m_blink_end = 0; end
      end
      2: begin
        if (detach_i) begin m_state = 3; m_entry = edges; end
        else if (activity_i) m_blink_end = (edges / TD + BT) * TD;
      end
      3: if (edges - m_entry == DT * TD) begin m_state = 1; m_entry = edges; end
      default: m_state = 0;
    endcase
  endtask

  task automatic compare();
    bit e_rstn, e_pu, e_led;
    logic [1:0] e_state;
    e_state = 2'(m_state);
    e_rstn  = (m_state == 1) || (m_state == 2);
    e_pu    = (m_state == 2);
    e_led   = (m_state == 1) || ((m_state == 2) && (edges >= m_blink_end));
    checks++;
    if (state_o !== e_state || rstn_o !== e_rstn || usb_pu_o !== e_pu || led_o !== e_led) begin
      failures++;
      $display("FAIL model edge=%0d: state/rstn/pu/led got %0d/%b/%b/%b, expected %0d/%b/%b/%b",
               edges, state_o, rstn_o, usb_pu_o, led_o, e_state, e_rstn, e_pu, e_led);
    end
  endtask

  // One clock cycle: the edge samples current inputs, new inputs follow, outputs checked at negedge.
  task automatic cyc(input bit r, input bit d, input bit a);
    @(posedge clk_i);
    if (!rst_i) model_edge();
    #2;
    detach_i   = d;
    activity_i = a;
    if (r && !rst_i) begin
      rst_i = 1'b1;
      model_reset();
      #1;
      chk_eq("async_rst_outputs", int'({rstn_o, usb_pu_o, led_o, state_o}), 0);
    end else begin
      rst_i = r;
      if (r) model_reset();
    end
    @(negedge clk_i);
    compare();
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, output int e);
    e = -1;
    for (int k = 0; k < budget; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (state_o === s) begin
        e = edges;
        break;
      end
    end
    if (e < 0) begin
      checks++;
      failures++;
      $display("FAIL timeout waiting for state %0d, state_o=%0d", s, state_o);
    end
  endtask

  task automatic wait_led_on(input int budget, output int e);
    e = -1;
    for (int k = 0; k < budget; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (led_o === 1'b1) begin
        e = edges;
        break;
      end
    end
    if (e < 0) begin
      checks++;
      failures++;
      $display("FAIL timeout waiting for led_o=1, led_o=%b", led_o);
    end
  endtask

  task automatic power_up(input string tag);
    int e1, e2;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    wait_state(2'd1, 20, e1);
    chk_eq({tag, "_wait_edge"}, e1, 3);
    chk_eq({tag, "_led_in_wait"}, int'(led_o), 1);
    wait_state(2'd2, 80, e2);
    chk_eq({tag, "_attach_delay"}, e2 - e1, 32);
  endtask

  initial begin
    int p1, p2, e, e2, pw, rst_left;
    bit r, d, a;
    rst_i      = 1'b1;
    detach_i   = 1'b0;
    activity_i = 1'b0;
    model_reset();

    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    chk_eq("reset_outputs", int'({rstn_o, usb_pu_o, led_o, state_o}), 0);
    power_up("powerup");

    // Single blink, then a retrigger four cycles after a fresh pulse.
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    p1 = edges + 1;
    cyc(1'b0, 1'b0, 1'b0);
    chk_eq("blink_led_off", int'(led_o), 0);
    wait_led_on(40, e);
    chk_rng("blink_off_cycles", e - p1, 9, 15);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    p1 = edges + 1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    p2 = edges + 1;
    chk_eq("retrigger_gap", p2 - p1, 4);
    wait_led_on(40, e);
    chk_rng("retrigger_off_cycles", e - p2, 9, 15);

    // Soft detach from ATTACHED.
    cyc(1'b0, 1'b1, 1'b0);
    p1 = edges + 1;
    cyc(1'b0, 1'b0, 1'b0);
    chk_eq("detach_state", int'(state_o), 3);
    chk_eq("detach_pu_rstn", int'({usb_pu_o, rstn_o}), 0);
    wait_state(2'd1, 40, e);
    chk_eq("detach_duration", e - p1, 20);
    wait_state(2'd2, 80, e2);
    chk_eq("reattach_delay", e2 - e, 32);

    // Detach coinciding with the final WAIT tick, with ignored activity in WAIT.
    cyc(1'b0, 1'b1, 1'b0);
    wait_state(2'd1, 40, e);
    for (int k = 0; k < 30; k++) cyc(1'b0, 1'b0, (k == 5 || k == 20));
    cyc(1'b0, 1'b1, 1'b0);
    pw = edges + 1;
    chk_eq("wait_detach_cycle", pw - e, 32);
    cyc(1'b0, 1'b0, 1'b0);
    chk_eq("wait_detach_no_attach", int'({state_o, usb_pu_o}), 2);
    wait_state(2'd2, 80, e2);
    chk_eq("wait_detach_attach_delay", e2 - pw, 32);

    // Detach and activity ignored inside DETACH.
    cyc(1'b0, 1'b1, 1'b0);
    p1 = edges + 1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    wait_state(2'd1, 40, e);
    chk_eq("ignored_detach_duration", e - p1, 20);
    wait_state(2'd2, 80, e2);

    // Asynchronous reset mid-ATTACHED, detach ignored while in reset.
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk_eq("midrst_state", int'(state_o), 0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    power_up("rerun");

    // Randomized traffic with occasional resets.
    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rst_left > 0) begin
        r = 1'b1;
        rst_left--;
      end else if ($urandom_range(0, 399) == 0) begin
        r = 1'b1;
        rst_left = $urandom_range(0, 3);
      end else begin
        r = 1'b0;
      end
      d = ($urandom_range(0, 99) < 2);
      a = ($urandom_range(0, 99) < 12);
      cyc(r, d, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
